// File: rtl/vga_pkg.sv
// Shared constants and types for the VGA pixel pipeline.
package vga_pkg;

  localparam int TXT_COLS  = 16;
  localparam int TXT_ROWS  = 8;
  localparam int CHAR_W    = 8;
  localparam int CHAR_H    = 16;
  localparam int TXT_CHARS = TXT_COLS * TXT_ROWS;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TYPING = 2'd1,
    DONE   = 2'd2
  } txt_state_t;

endpackage

// File: rtl/delay.sv
// Fixed-depth register chain used to keep sideband signals aligned with the pixel pipeline.
module delay #(
  parameter int DATA_W = 1,
  parameter int STAGES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  logic [DATA_W-1:0] pipe [STAGES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= din;
      for (int i = 1; i < STAGES; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign dout = pipe[STAGES-1];

endmodule

// File: rtl/game_text_render.sv
// 16x8 character text box overlaid on the VGA stream, revealed one character at a time.
module game_text_render
  import vga_pkg::*;
#(
  parameter int          X_POS           = 256,
  parameter int          Y_POS           = 200,
  parameter logic [11:0] TXT_COLOR       = 12'hFFF,
  parameter int          FRAMES_PER_CHAR = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] hcount_in,
  input  logic [10:0] vcount_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        hblnk_in,
  input  logic        vblnk_in,
  input  logic [11:0] rgb_in,
  input  logic        start,
  input  logic        skip,
  output logic [7:0]  char_xy,
  input  logic [6:0]  char_code,
  output logic [10:0] font_addr,
  input  logic [7:0]  char_pixels,
  output logic [10:0] hcount_out,
  output logic [10:0] vcount_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        hblnk_out,
  output logic        vblnk_out,
  output logic [11:0] rgb_out,
  output logic        done
);

  localparam logic [10:0] X0      = 11'(X_POS);
  localparam logic [10:0] Y0      = 11'(Y_POS);
  localparam logic [10:0] BOX_W   = 11'(TXT_COLS * CHAR_W);
  localparam logic [10:0] BOX_H   = 11'(TXT_ROWS * CHAR_H);
  localparam logic [7:0]  CHARS   = 8'(TXT_CHARS);
  localparam logic [15:0] FC_LAST = 16'(FRAMES_PER_CHAR - 1);

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v >= CHARS) ? CHARS : v + 8'd1;
  endfunction

  // Reveal FSM; counters only move on the frame tick so a frame renders consistently.
  txt_state_t  state;
  logic [7:0]  reveal_cnt;
  logic [15:0] frame_cnt;
  logic        frame_tick;

  assign frame_tick = (hcount_in == 11'd0) && (vcount_in == 11'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      reveal_cnt <= 8'd0;
      frame_cnt  <= 16'd0;
    end else if (start) begin
      state      <= TYPING;
      reveal_cnt <= 8'd0;
      frame_cnt  <= 16'd0;
    end else if (skip && state != DONE) begin
      state      <= DONE;
      reveal_cnt <= CHARS;
      frame_cnt  <= 16'd0;
    end else if (state == TYPING && frame_tick) begin
      if (frame_cnt == FC_LAST) begin
        frame_cnt  <= 16'd0;
        reveal_cnt <= sat_inc(reveal_cnt);
        if (sat_inc(reveal_cnt) == CHARS) state <= DONE;
      end else begin
        frame_cnt <= frame_cnt + 16'd1;
      end
    end
  end

  assign done = (state == DONE);

  // Box geometry; negative offsets wrap large and fall outside the box.
  logic [10:0] rel_x, rel_y;
  logic        in_box, visible;
  logic [6:0]  idx;

  assign rel_x   = hcount_in - X0;
  assign rel_y   = vcount_in - Y0;
  assign in_box  = (rel_x < BOX_W) && (rel_y < BOX_H);
  assign idx     = {rel_y[6:4], rel_x[6:3]};
  assign visible = ({1'b0, idx} < reveal_cnt);

  // ---- stage 1: text ROM address and per-pixel attributes
  logic [3:0]  char_line_p1;
  logic [2:0]  bit_sel_p1;
  logic        in_box_p1, vis_p1, blank_p1, vld_p1;
  logic [11:0] rgb_p1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      char_xy      <= 8'd0;
      char_line_p1 <= 4'd0;
      bit_sel_p1   <= 3'd0;
      in_box_p1    <= 1'b0;
      vis_p1       <= 1'b0;
      blank_p1     <= 1'b0;
      rgb_p1       <= 12'd0;
      vld_p1       <= 1'b0;
    end else begin
      char_xy      <= {1'b0, rel_y[6:4], rel_x[6:3]};
      char_line_p1 <= rel_y[3:0];
      bit_sel_p1   <= rel_x[2:0];
      in_box_p1    <= in_box;
      vis_p1       <= visible;
      blank_p1     <= hblnk_in | vblnk_in;
      rgb_p1       <= rgb_in;
      vld_p1       <= 1'b1;
    end
  end

  // ---- stage 2: char_code is back; form the font address
  logic [3:0] char_line_p2;
  logic       vld_p2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      char_line_p2 <= 4'd0;
      vld_p2       <= 1'b0;
    end else begin
      char_line_p2 <= char_line_p1;
      vld_p2       <= vld_p1;
    end
  end

  // Hold the address at zero until real ROM data has flowed in after reset.
  assign font_addr = vld_p2 ? {char_code, char_line_p2} : 11'd0;

  // ---- stage 3: glyph row is back; pixel attributes catch up through the delay line
  logic [11:0] rgb_p3;
  logic        in_box_p3, vis_p3, blank_p3;
  logic [2:0]  bit_sel_p3;

  delay #(.DATA_W(18), .STAGES(2)) u_side_dly (
    .clk  (clk),
    .rst  (rst),
    .din  ({rgb_p1, in_box_p1, vis_p1, blank_p1, bit_sel_p1}),
    .dout ({rgb_p3, in_box_p3, vis_p3, blank_p3, bit_sel_p3})
  );

  // ---- stage 4: overlay and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rgb_out <= 12'd0;
    end else if (in_box_p3 && vis_p3 && !blank_p3 && char_pixels[3'd7 - bit_sel_p3]) begin
      rgb_out <= TXT_COLOR;
    end else begin
      rgb_out <= rgb_p3;
    end
  end

  logic [25:0] timing_p4;

  delay #(.DATA_W(26), .STAGES(4)) u_timing_dly (
    .clk  (clk),
    .rst  (rst),
    .din  ({hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in}),
    .dout (timing_p4)
  );

  assign {hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out} = timing_p4;

endmodule

// File: tb/tb_game_text_render.sv
// Randomized bench for game_text_render with ROM models and a frame-level reveal model.
module tb_game_text_render;

  localparam int          XP  = 256;
  localparam int          YP  = 200;
  localparam int          FPC = 2;
  localparam logic [11:0] TXT = 12'hABC;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [10:0] hcount_in = '0, vcount_in = '0;
  logic        hsync_in = 0, vsync_in = 0, hblnk_in = 0, vblnk_in = 0;
  logic [11:0] rgb_in = '0;
  logic        start = 0, skip = 0;
  logic [7:0]  char_xy;
  logic [6:0]  char_code = '0;
  logic [10:0] font_addr;
  logic [7:0]  char_pixels = '0;
  logic [10:0] hcount_out, vcount_out;
  logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
  logic [11:0] rgb_out;
  logic        done;

  game_text_render #(.X_POS(XP), .Y_POS(YP), .TXT_COLOR(TXT), .FRAMES_PER_CHAR(FPC)) dut (
    .clk(clk), .rst(rst),
    .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
    .rgb_in(rgb_in), .start(start), .skip(skip),
    .char_xy(char_xy), .char_code(char_code),
    .font_addr(font_addr), .char_pixels(char_pixels),
    .hcount_out(hcount_out), .vcount_out(vcount_out),
    .hsync_out(hsync_out), .vsync_out(vsync_out), .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
    .rgb_out(rgb_out), .done(done)
  );

  always #5 clk = ~clk;

  // Registered ROM models, one cycle of latency each.
  logic [6:0] text_rom [256];
  logic [7:0] font_rom [2048];
  always @(posedge clk) begin
    char_code   <= text_rom[char_xy];
    char_pixels <= font_rom[font_addr];
  end

  typedef struct packed {
    logic [10:0] h, v;
    logic        hs, vs, hb, vb;
    logic [11:0] rgb;
  } out_t;

  out_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reveal model: characters shown = completed frame groups since start, capped at 128.
  bit m_typing = 0, m_all = 0;
  int m_ticks = 0;

  function automatic int m_revealed();
    int r;
    if (m_all) return 128;
    if (!m_typing) return 0;
    r = m_ticks / FPC;
    return (r > 128) ? 128 : r;
  endfunction

  function automatic bit m_done();
    return m_all || (m_typing && (m_ticks / FPC >= 128));
  endfunction

  function automatic out_t expect_px(int h, int v, bit hs, bit vs, bit hb, bit vb, logic [11:0] rgb);
    out_t e;
    int rx, ry, cidx, code, frow;
    bit lit;
    rx = (h - XP + 2048) % 2048;
    ry = (v - YP + 2048) % 2048;
    lit = 0;
    if (rx < 128 && ry < 128 && !hb && !vb) begin
      cidx = (ry / 16) * 16 + rx / 8;
      if (cidx < m_revealed()) begin
        code = int'(text_rom[cidx]);
        frow = int'(font_rom[code * 16 + ry % 16]);
        lit  = ((frow >> (7 - rx % 8)) & 1) == 1;
      end
    end
    e.h = 11'(h); e.v = 11'(v);
    e.hs = hs; e.vs = vs; e.hb = hb; e.vb = vb;
    e.rgb = lit ? TXT : rgb;
    return e;
  endfunction

  // One pixel per cycle; entered and left at a falling edge.
  task automatic step(input int h, input int v, input bit st, input bit sk);
    out_t e, got;
    bit hs, vs, hb, vb;
    logic [11:0] rgb;
    hs = 1'($urandom_range(0, 1)); vs = 1'($urandom_range(0, 1));
    hb = ($urandom_range(0, 7) == 0); vb = ($urandom_range(0, 7) == 0);
    rgb = 12'($urandom);
    hcount_in = 11'(h); vcount_in = 11'(v);
    hsync_in = hs; vsync_in = vs; hblnk_in = hb; vblnk_in = vb;
    rgb_in = rgb; start = st; skip = sk;
    exp_q.push_back(expect_px(h, v, hs, vs, hb, vb, rgb));
    if (st) begin
      m_typing = 1; m_all = 0; m_ticks = 0;
    end else if (sk) begin
      m_all = 1;
    end else if (h == 0 && v == 0 && m_typing && !m_all) begin
      m_ticks++;
    end
    @(posedge clk);
    @(negedge clk);
    start = 0; skip = 0;
    if (exp_q.size() == 4) begin
      e = exp_q.pop_front();
      got = {hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out, rgb_out};
      vectors++;
      if (got !== e) begin
        miscompares++;
        $display("FAIL pixel_out: got %h expected %h", got, e);
      end
    end
    vectors++;
    if (done !== m_done()) begin
      miscompares++;
      $display("FAIL done: got %b expected %b", done, m_done());
    end
  endtask

  // Frame tick, then a mix of random, boundary and reveal-edge pixels.
  task automatic run_frame(input int npix);
    int h, v, mode, t;
    step(0, 0, 0, 0);
    for (int i = 0; i < npix; i++) begin
      mode = $urandom_range(0, 7);
      if (mode < 5) begin
        h = XP + $urandom_range(0, 127); v = YP + $urandom_range(0, 127);
      end else if (mode == 5) begin
        h = XP + (($urandom_range(0, 1) == 1) ? 127 : 128) + ($urandom_range(0, 1) == 1 ? -256 : 0);
        v = YP + (($urandom_range(0, 1) == 1) ? 127 : 128);
        if ($urandom_range(0, 1) == 1) v = YP - 1;
        if (h < 0) h = XP - 1;
      end else begin
        t = m_revealed() - 1 + $urandom_range(0, 1);
        if (t < 0) t = 0;
        if (t > 127) t = 127;
        h = XP + (t % 16) * 8 + $urandom_range(0, 7);
        v = YP + (t / 16) * 16 + $urandom_range(0, 15);
      end
      step(h, v, 0, 0);
    end
  endtask

  task automatic async_reset_check(input string name);
    logic [70:0] all_out;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    all_out = {char_xy, font_addr, hcount_out, vcount_out, hsync_out, vsync_out,
               hblnk_out, vblnk_out, rgb_out, done, 14'd0};
    vectors++;
    if (all_out !== '0) begin
      miscompares++;
      $display("FAIL %s: got %h expected 0", name, all_out);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    m_typing = 0; m_all = 0; m_ticks = 0;
  endtask

  task automatic test_reset();
    logic [70:0] all_out;
    repeat (3) @(negedge clk);
    all_out = {char_xy, font_addr, hcount_out, vcount_out, hsync_out, vsync_out,
               hblnk_out, vblnk_out, rgb_out, done, 14'd0};
    vectors++;
    if (all_out !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %h expected 0", all_out);
    end
    rst = 1'b0;
  endtask

  task automatic test_idle_frame();
    run_frame(200);
    run_frame(100);
  endtask

  task automatic test_geometry();
    logic [10:0] fa_exp;
    step(XP + 9, YP + 35, 0, 0);
    vectors++;
    if (char_xy !== 8'h21) begin
      miscompares++;
      $display("FAIL char_xy: got %h expected 21", char_xy);
    end
    fa_exp = {text_rom[8'h21], 4'd3};
    step(5, 5, 0, 0);
    vectors++;
    if (font_addr !== fa_exp) begin
      miscompares++;
      $display("FAIL font_addr: got %h expected %h", font_addr, fa_exp);
    end
  endtask

  task automatic test_typing();
    step(1000, 5, 1, 0);
    for (int f = 0; f < 128 * FPC + 2; f++) run_frame(10);
  endtask

  task automatic test_skip();
    step(1000, 5, 1, 0);
    for (int f = 0; f < 3 * FPC + 1; f++) run_frame(10);
    step(1000, 5, 0, 1);
    run_frame(80);
  endtask

  task automatic test_start_skip();
    step(1000, 5, 1, 1);
    for (int f = 0; f < 4 * FPC; f++) run_frame(20);
  endtask

  task automatic test_reset_mid();
    step(1000, 5, 1, 0);
    for (int f = 0; f < 6 * FPC; f++) run_frame(8);
    async_reset_check("reset_mid_outputs");
    for (int f = 0; f < 3; f++) run_frame(40);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) text_rom[i] = 7'($urandom);
    for (int i = 0; i < 2048; i++) font_rom[i] = 8'($urandom);
    test_reset();
    test_idle_frame();
    test_geometry();
    test_typing();
    test_skip();
    test_start_skip();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/game_text_render.md
# game_text_render

Pixel-pipeline stage that draws a 16×8 character text box on the VGA stream with a typewriter reveal effect. It sits between the VGA timing/background path and the game-content text ROM. It drives the ROM's `char_xy` address and consumes the returned 7-bit `char_code`. It then addresses the shared font ROM, overlays glyph pixels on `rgb_in`, and forwards delayed timing signals downstream.

## Interface
Parameters:
- `X_POS`, 256: left edge of the text box in pixels.
- `Y_POS`, 200: top edge of the text box in pixels.
- `TXT_COLOR`, 12'hFFF: colour of glyph foreground pixels.
- `FRAMES_PER_CHAR`, 4: frames between consecutive revealed characters, ≥1.

Ports:
- `clk` in 1: pixel clock.
- `rst` in 1: asynchronous, active-high reset.
- `hcount_in`, `vcount_in` in 11 each: pixel position.
- `hsync_in`, `vsync_in`, `hblnk_in`, `vblnk_in` in 1 each: timing signals.
- `rgb_in` in 12: background colour.
- `start` in 1: one-cycle pulse that starts a reveal from character 0.
- `skip` in 1: one-cycle pulse that reveals all characters immediately.
- `char_xy` out 8: text ROM address `{row[3:0], col[3:0]}`.
- `char_code` in 7: text ROM data, registered, 1-cycle latency.
- `font_addr` out 11: font ROM address `{char_code, char_line[3:0]}`.
- `char_pixels` in 8: font ROM row, registered, 1-cycle latency. Bit 7 is the leftmost pixel.
- `hcount_out`, `vcount_out`, `hsync_out`, `vsync_out`, `hblnk_out`, `vblnk_out`, `rgb_out`: delayed copies and overlaid colour.
- `done` out 1: high while all 128 characters are revealed.

## Operation
Box geometry:
- `rel_x = hcount_in - X_POS` and `rel_y = vcount_in - Y_POS`, each 11 bits.
- The pixel is in the box when both values are < 128 as unsigned. Negative differences wrap large and are therefore outside the box.
- `col = rel_x[6:3]`, `row = {1'b0, rel_y[6:4]}`, `char_line = rel_y[3:0]`, `bit_sel = rel_x[2:0]`.
- Character index `idx = {row[2:0], col}`, range 0..127.

Reveal FSM states:
- IDLE: reset state, nothing drawn. `start` → TYPING with `reveal_cnt=0` and `frame_cnt=0`.
- TYPING: `frame_tick` is one cycle when `hcount_in==0 && vcount_in==0`. On each tick `frame_cnt` increments. When it reaches `FRAMES_PER_CHAR-1` it clears and `reveal_cnt` increments. When `reveal_cnt` reaches 128 the FSM goes to DONE.
- DONE: `reveal_cnt=128`, `done=1`. A `start` pulse restarts TYPING from 0.
- `skip` in TYPING or IDLE: `reveal_cnt=128` and the FSM goes to DONE on the next cycle.
- `start` and `skip` in the same cycle: `start` wins.
- `reveal_cnt` is 8 bits. It saturates at 128 and never wraps.
- `reveal_cnt` updates only at frame_tick, so it is stable across the visible frame.

A character is visible when `idx < reveal_cnt`. This is evaluated on the stage-1 `idx` against the current `reveal_cnt`.

Overlay: `rgb_out = TXT_COLOR` when `in_box && visible && char_pixels[7-bit_sel] && !(hblnk||vblnk)` (all delayed to match). Otherwise `rgb_out` is the delayed `rgb_in`.

## Timing
- Stage 1, t+1: register `char_xy`, `char_line`, `bit_sel`, `in_box`, `visible`, timing, and rgb.
- Stage 2, t+2: the ROM presents `char_code`. `font_addr = {char_code, char_line_d1}` is combinational. Sideband signals are delayed one more stage.
- Stage 3, t+3: the font ROM presents `char_pixels`. Sideband signals are delayed one more stage.
- Stage 4, t+4: registered outputs. Total latency from input to all `*_out` signals is 4 cycles, and every output is aligned to that.
- Reset values: all outputs 0, including `char_xy=0`, `font_addr=0`, `rgb_out=0` and `done=0`. After reset the FSM is in IDLE with both counters 0.
- Reset mid-reveal aborts immediately. The text stays hidden until the next `start`.

## Structure
- Add to `vga_pkg`:
  - Box constants `TXT_COLS=16`, `TXT_ROWS=8`, `CHAR_W=8`, `CHAR_H=16`.
  - Typedef `txt_state_t` {IDLE, TYPING, DONE}.
- Sub-module `delay`, parameterised width and depth: carries the sideband and timing bundle through the 4 stages.
- The reveal FSM and counters stay in the top module.

## Test plan
- After reset, no `start`, one full frame: `rgb_out == rgb_in` delayed 4 cycles everywhere, and `done=0`.
- Pixel at `hcount_in=X_POS+9`, `vcount_in=Y_POS+35`: `char_xy=8'h21` at t+1, and `font_addr={char_code,4'd3}` at t+2.
- `start`, `FRAMES_PER_CHAR=1`, glyph for index 0x01 has bit 7 set on row 0: that pixel is `TXT_COLOR` from frame 2 onward, index 0x02 is still background, and `done` rises after 128 frame_ticks.
- `skip` in TYPING: `done=1` on the next cycle, and the whole box renders in the same frame.
- `start` and `skip` in the same cycle: the FSM enters TYPING with `reveal_cnt=0` and `done=0`.
- `rst` asserted mid-TYPING: all outputs 0 asynchronously. After release the FSM is in IDLE and no glyphs are drawn.
